// File: rtl/clock_rate_generator.sv
// clock_rate_generator: produces half- and quarter-period strobes for the
// downstream clock_generation block and sequences clean start/stop so the
// generated clock always begins from and parks at its idle level.
`timescale 1ns/1ps

package clks_alot_p;
  localparam int COUNTER_WIDTH = 16;
endpackage

module clock_rate_generator #(
  parameter int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH
) (
  input  logic                     clk,
  input  logic                     async_rst_n,
  input  logic                     clk_en,
  input  logic                     enable_i,
  input  logic                     idle_polarity_i,
  input  logic [COUNTER_WIDTH-1:0] half_target_i,
  input  logic                     target_update_i,
  output logic                     clock_active_o,
  output logic                     clear_state_o,
  output logic                     set_clock_low_o,
  output logic                     set_clock_high_o,
  output logic                     half_rate_elapsed_o,
  output logic                     quarter_rate_elapsed_o,
  output logic                     phase_o
);

  typedef enum logic [1:0] {IDLE, PRIME, RUNNING, STOPPING} state_t;

  localparam logic [COUNTER_WIDTH-1:0] ONE   = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] MIN_T = COUNTER_WIDTH'(2);

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] count;
  logic [COUNTER_WIDTH-1:0] active_t;
  logic [COUNTER_WIDTH-1:0] pending_t;
  logic                     pending_v;
  logic                     phase;
  logic                     clear_q;

  logic [COUNTER_WIDTH-1:0] target_clamped;
  logic [COUNTER_WIDTH-1:0] quarter_t;
  logic                     active;
  logic                     quiet_stop;
  logic                     advance;
  logic                     boundary;
  logic                     start;

  // Half periods shorter than 2 cannot produce a distinct quarter point.
  assign target_clamped = (half_target_i < MIN_T) ? MIN_T : half_target_i;
  assign quarter_t      = active_t >> 1;

  assign active     = (state == RUNNING) || (state == STOPPING);
  // Stop request while already sitting at the idle level: leave at once, no strobes.
  assign quiet_stop = (state == RUNNING) && !enable_i && (phase == idle_polarity_i);
  assign advance    = clk_en && active && !quiet_stop;
  assign boundary   = advance && (count == active_t - ONE);
  // Reset gating keeps the force pulses quiet while reset is held.
  assign start      = async_rst_n && clk_en && (state == IDLE) && enable_i;

  assign clock_active_o         = active;
  assign clear_state_o          = clear_q && clk_en;
  assign set_clock_low_o        = start && !idle_polarity_i;
  assign set_clock_high_o       = start && idle_polarity_i;
  assign half_rate_elapsed_o    = boundary;
  assign quarter_rate_elapsed_o = advance && (count == quarter_t - ONE);
  assign phase_o                = phase;

  // Sequencing, half-period counting and target bookkeeping.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state     <= IDLE;
      count     <= '0;
      active_t  <= MIN_T;
      pending_t <= MIN_T;
      pending_v <= 1'b0;
      phase     <= 1'b0;
      clear_q   <= 1'b0;
    end else if (clk_en) begin
      clear_q <= 1'b0;
      case (state)
        IDLE: begin
          if (target_update_i) begin
            active_t  <= target_clamped;
            pending_t <= target_clamped;
            pending_v <= 1'b0;
          end else if (enable_i && pending_v) begin
            active_t  <= pending_t;
            pending_v <= 1'b0;
          end
          if (enable_i) begin
            count <= '0;
            phase <= idle_polarity_i;
            state <= PRIME;
          end
        end
        PRIME: begin
          state <= RUNNING;
          if (target_update_i) begin
            pending_t <= target_clamped;
            pending_v <= 1'b1;
          end
        end
        RUNNING, STOPPING: begin
          if (quiet_stop) begin
            state   <= IDLE;
            count   <= '0;
            clear_q <= 1'b1;
            if (target_update_i) begin
              pending_t <= target_clamped;
              pending_v <= 1'b1;
            end
          end else if (boundary) begin
            count <= '0;
            phase <= ~phase;
            if (target_update_i) begin
              active_t  <= target_clamped;
              pending_t <= target_clamped;
              pending_v <= 1'b0;
            end else if (pending_v) begin
              active_t  <= pending_t;
              pending_v <= 1'b0;
            end
            // The boundary just returned phase to idle, so a stop can complete here.
            if (enable_i) begin
              state <= RUNNING;
            end else begin
              state   <= IDLE;
              clear_q <= 1'b1;
            end
          end else begin
            count <= count + ONE;
            state <= enable_i ? RUNNING : STOPPING;
            if (target_update_i) begin
              pending_t <= target_clamped;
              pending_v <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_rate_generator.sv
// Testbench for clock_rate_generator: a fixed start/run/stop vector table,
// directed corner sequences and randomized traffic against a reference model.
`timescale 1ns/1ps

module tb_clock_rate_generator;

  localparam int W = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce    = 1'b0;
  logic         en    = 1'b0;
  logic         pol   = 1'b0;
  logic         upd   = 1'b0;
  logic [W-1:0] tgt   = '0;

  logic act_o, clr_o, sl_o, sh_o, half_o, qtr_o, ph_o;
  logic [6:0] got;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a period is tracked as cycles left until its boundary.
  bit   m_run, m_prime, m_clr, m_pv;
  logic m_ph;
  int   m_T, m_pT, m_left;
  logic seen_half, seen_clear;

  clock_rate_generator #(.COUNTER_WIDTH(W)) dut (
    .clk                    (clk),
    .async_rst_n            (rst_n),
    .clk_en                 (ce),
    .enable_i               (en),
    .idle_polarity_i        (pol),
    .half_target_i          (tgt),
    .target_update_i        (upd),
    .clock_active_o         (act_o),
    .clear_state_o          (clr_o),
    .set_clock_low_o        (sl_o),
    .set_clock_high_o       (sh_o),
    .half_rate_elapsed_o    (half_o),
    .quarter_rate_elapsed_o (qtr_o),
    .phase_o                (ph_o)
  );

  // {active, clear, set_low, set_high, half, quarter, phase}
  assign got = {act_o, clr_o, sl_o, sh_o, half_o, qtr_o, ph_o};

  always #5 clk = ~clk;

  typedef struct packed {
    logic         ce;
    logic         en;
    logic         pol;
    logic         upd;
    logic [W-1:0] tgt;
    logic [6:0]   exp;
  } vec_t;

  vec_t tbl [15];

  function automatic void model_reset();
    m_run = 0; m_prime = 0; m_clr = 0; m_pv = 0;
    m_ph = 1'b0; m_T = 2; m_pT = 2; m_left = 1;
  endfunction

  function automatic logic [6:0] model_exp();
    logic quiet, adv, h, q, st;
    quiet = m_run && !en && (m_ph == pol);
    adv   = ce && m_run && !quiet;
    h     = adv && (m_left == 0);
    q     = adv && (m_left == (m_T + 1) / 2);
    st    = rst_n && ce && !m_run && !m_prime && en;
    return {m_run, m_clr && ce, st && !pol, st && pol, h, q, m_ph};
  endfunction

  function automatic void model_update();
    int  ct;
    bit  clr_next;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!ce) return;
    ct = (tgt < 2) ? 2 : int'(tgt);
    clr_next = 0;
    if (!m_run && !m_prime) begin
      if (upd) begin
        m_T = ct; m_pT = ct; m_pv = 0;
      end else if (en && m_pv) begin
        m_T = m_pT; m_pv = 0;
      end
      if (en) begin
        m_prime = 1; m_ph = pol; m_left = m_T - 1;
      end
    end else if (m_prime) begin
      m_prime = 0; m_run = 1;
      if (upd) begin m_pT = ct; m_pv = 1; end
    end else if (!en && m_ph == pol) begin
      m_run = 0; clr_next = 1;
      if (upd) begin m_pT = ct; m_pv = 1; end
    end else if (m_left == 0) begin
      m_ph = !m_ph;
      if (upd) begin
        m_T = ct; m_pT = ct; m_pv = 0;
      end else if (m_pv) begin
        m_T = m_pT; m_pv = 0;
      end
      m_left = m_T - 1;
      if (!en) begin m_run = 0; clr_next = 1; end
    end else begin
      m_left--;
      if (upd) begin m_pT = ct; m_pv = 1; end
    end
    m_clr = clr_next;
  endfunction

  task automatic model_cycle(input string name);
    logic [6:0] e;
    @(negedge clk);
    e = model_exp();
    seen_half  = half_o;
    seen_clear = clr_o;
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, got, e, $time);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wait_model(input int cnt, input logic ph, input string name);
    for (int k = 0; k < 60; k++) begin
      if (m_run && (m_T - 1 - m_left) == cnt && m_ph == ph) return;
      model_cycle(name);
    end
    n_vec++; n_err++;
    $display("FAIL %s: never reached count %0d phase %0b", name, cnt, ph);
  endtask

  task automatic stop_and_settle(input string name);
    en = 1'b0; upd = 1'b0; ce = 1'b1;
    for (int k = 0; k < 40 && (m_run || m_prime); k++) model_cycle(name);
    if (m_run || m_prime) begin
      n_vec++; n_err++;
      $display("FAIL %s: still active after 40 cycles, required idle", name);
    end
    model_cycle(name);
  endtask

  initial begin
    int last_k;
    int clears;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd4, 7'b0000000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 7'b0010000};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 7'b0000000};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 7'b1000000};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 7'b1000010};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 7'b1000000};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 7'b1000100};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 7'b1000001};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 7'b1000011};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 7'b1000001};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 7'b1000101};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 7'b1000000};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 7'b1000000};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 7'b0100000};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 7'b0000000};

    model_reset();
    #2;
    n_vec++;
    if (got !== 7'b0) begin
      n_err++;
      $display("FAIL reset_values: got %b expected %b", got, 7'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Start with T=4, run two half periods, quiet stop at idle phase.
    for (int i = 0; i < 15; i++) begin
      ce = tbl[i].ce; en = tbl[i].en; pol = tbl[i].pol;
      upd = tbl[i].upd; tgt = tbl[i].tgt;
      @(negedge clk);
      n_vec++;
      if (got !== tbl[i].exp) begin
        n_err++;
        $display("FAIL table[%0d]: got %b expected %b", i, got, tbl[i].exp);
      end
      @(posedge clk);
      model_update();
      #1;
    end

    // T=6, stop requested with phase away from idle: finishes the half period.
    ce = 1'b1; upd = 1'b1; tgt = 16'd6; en = 1'b0;
    model_cycle("t6_load");
    upd = 1'b0; en = 1'b1;
    wait_model(2, 1'b1, "t6_run");
    stop_and_settle("t6_stopping");

    // Same with phase at idle: immediate stop.
    en = 1'b1;
    wait_model(2, 1'b0, "t6_run0");
    stop_and_settle("t6_quiet_stop");

    // Pending update mid-period, direct update at boundary, clamp of 0.
    upd = 1'b1; tgt = 16'd4;
    model_cycle("upd_load4");
    upd = 1'b0; en = 1'b1;
    wait_model(1, 1'b0, "upd_run4");
    upd = 1'b1; tgt = 16'd8;
    model_cycle("upd_pending8");
    upd = 1'b0;
    wait_model(7, 1'b1, "upd_run8");
    upd = 1'b1; tgt = 16'd5;
    model_cycle("upd_boundary5");
    upd = 1'b0;
    wait_model(4, 1'b0, "upd_run5");
    upd = 1'b1; tgt = 16'd0;
    model_cycle("upd_boundary0");
    upd = 1'b0;
    for (int k = 0; k < 8; k++) model_cycle("upd_run2");
    stop_and_settle("upd_stop");

    // clk_en toggling with T=3: half strobes every 6 clk cycles.
    upd = 1'b1; tgt = 16'd3;
    model_cycle("gate_load3");
    upd = 1'b0; en = 1'b1;
    last_k = -1;
    for (int k = 0; k < 48; k++) begin
      ce = (k % 2 == 0);
      model_cycle("gate_run");
      if (seen_half) begin
        if (last_k >= 0) begin
          n_vec++;
          if (k - last_k != 6) begin
            n_err++;
            $display("FAIL half_period_gated: got %0d clk cycles expected 6", k - last_k);
          end
        end
        last_k = k;
      end
    end
    ce = 1'b1;

    // Re-enable while STOPPING: no clear pulse, running continues.
    wait_model(0, 1'b1, "reassert_run");
    en = 1'b0;
    model_cycle("reassert_drop");
    en = 1'b1;
    clears = 0;
    for (int k = 0; k < 10; k++) begin
      model_cycle("reassert_resume");
      if (seen_clear) clears++;
    end
    n_vec++;
    if (clears != 0) begin
      n_err++;
      $display("FAIL reassert_no_clear: got %0d clear pulses expected 0", clears);
    end

    // Asynchronous reset while running.
    wait_model(1, 1'b0, "rst_run");
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (got !== 7'b0) begin
      n_err++;
      $display("FAIL reset_mid_run: got %b expected %b", got, 7'b0);
    end
    model_reset();
    model_cycle("rst_held");
    model_cycle("rst_held");
    rst_n = 1'b1; en = 1'b0;
    for (int k = 0; k < 3; k++) model_cycle("rst_idle");
    en = 1'b1;
    for (int k = 0; k < 8; k++) model_cycle("rst_restart");
    stop_and_settle("rst_stop");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      ce  = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) en = ~en;
      upd = ($urandom_range(0, 9) == 0);
      tgt = W'($urandom_range(0, 9));
      if (!m_run && !m_prime && !en && $urandom_range(0, 7) == 0)
        pol = 1'($urandom_range(0, 1));
      model_cycle("random");
    end
    stop_and_settle("final_stop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clock_rate_generator.md
# clock_rate_generator

Upstream timing source for `clock_generation`: turns a programmed half-period length into per-cycle `half_rate_elapsed` and `quarter_rate_elapsed` strobes. It sequences clock start and stop through `set_clock_low`/`set_clock_high`, `clock_active` and `clear_state`, so the generated clock always starts from, and parks at, its idle level without runt phases. All outputs connect directly to the like-named inputs of `clock_generation`.

## Interface
- `COUNTER_WIDTH`, default `clks_alot_p::COUNTER_WIDTH` (16): width of the half-period counter and target.
- `clk` in 1: system clock.
- `async_rst_n` in 1: reset, asynchronous, active-low.
- `clk_en` in 1: cycle qualifier. When low, all state holds and all pulse outputs are 0.
- `enable_i` in 1: request the generated clock to run (level).
- `idle_polarity_i` in 1: level the generated clock rests at when stopped. Quasi-static; only changes while `clock_active_o`=0.
- `half_target_i` in COUNTER_WIDTH: half-period length in `clk_en` cycles. Values 0 and 1 clamp to 2.
- `target_update_i` in 1: sample `half_target_i` into the pending register.
- `clock_active_o` out 1: generated clock running.
- `clear_state_o` out 1: one-cycle pulse when the clock goes inactive.
- `set_clock_low_o`, `set_clock_high_o` out 1: one-cycle force pulses at start.
- `half_rate_elapsed_o`, `quarter_rate_elapsed_o` out 1: phase strobes.
- `phase_o` out 1: expected level of the generated clock.

## Operation
- Registered state: `state` (IDLE, PRIME, RUNNING, STOPPING), `count`, `active_T`, `pending_T`, `pending_v`, `phase`, `clear_q`.
- `Q` = `active_T>>1`. With the minimum `T`=2, `Q`=1.
- `target_update_i`: `pending_T` ← clamp(`half_target_i`), and `pending_v` ← 1.
  - In IDLE the value goes directly to `active_T` as well, and `pending_v` stays 0.
  - A later update overwrites an earlier pending one.
- IDLE (`clock_active_o`=0):
  - On `clk_en && enable_i`: `count` ← 0, `phase` ← `idle_polarity_i`, go to PRIME.
  - In that same cycle, pulse `set_clock_high_o` if `idle_polarity_i`, else pulse `set_clock_low_o`.
- PRIME: on `clk_en`, go to RUNNING. `clock_active_o` is still 0.
- RUNNING (`clock_active_o`=1):
  - Each `clk_en` cycle, `count` increments.
  - `quarter_rate_elapsed_o` = `clk_en` && `count`==`Q`-1.
  - `half_rate_elapsed_o` = `clk_en` && `count`==`active_T`-1. At that boundary: `count` ← 0, `phase` toggles, and if `pending_v` then `active_T` ← `pending_T` and `pending_v` ← 0.
  - If `target_update_i` coincides with a boundary, `active_T` takes the new clamped input directly.
- `enable_i` low while RUNNING:
  - If `phase`==`idle_polarity_i`: go to IDLE next `clk_en` cycle; no strobes in that cycle.
  - Otherwise go to STOPPING; counting and strobes continue.
- STOPPING: at the next `half_rate_elapsed_o` (`phase` becomes idle), go to IDLE.
  - If `enable_i` reasserts before that boundary, return to RUNNING with no count disturbance.
- Entering IDLE from RUNNING or STOPPING: `clear_state_o`=1 for exactly one cycle (registered).
  - `count` ← 0 and `pending_v` is kept; the pending value is applied on the next start.
- Outputs:
  - `clock_active_o` = state ∈ {RUNNING, STOPPING}.
  - Force and strobe outputs are combinational decodes of registered state AND `clk_en`.
  - `clear_state_o` is a registered pulse, held 0 while `clk_en`=0.

## Timing
- Reset values:
  - state IDLE; `count`, `phase`, `pending_v`, `clear_q` = 0; `active_T` = `pending_T` = 2.
  - All outputs 0.
- Reset deassertion mid-operation requires no special handling; the block restarts from IDLE.
- Start latency: `enable_i` sampled at edge N (with `clk_en`) → force pulse during cycle N → `clock_active_o`=1 from N+2. The first `half_rate_elapsed_o` arrives `T` `clk_en` cycles after that.
- Steady state: `half_rate_elapsed_o` period = `T` `clk_en` cycles; quarter strobe `Q` cycles after each half boundary (`Q`-1 cycles after count 0).
- Stop: `clock_active_o` drops the cycle after the final boundary; `clear_state_o` is high in that same cycle.
- `count` never exceeds `active_T`-1. No wrap at 2^COUNTER_WIDTH is possible because `T` ≤ 2^W-1.
- Gaps in `clk_en` stretch all timing; the strobes never fire with `clk_en` low.

## Test plan
- Reset, `T`=4, `idle_polarity_i`=0, `enable_i`↑: `set_clock_low_o` pulse; `clock_active_o` high 2 cycles later; quarter strobes at `count`=1 and half strobes at `count`=3, period 4; `phase_o` toggles 0→1→0.
- Running with `T`=6 and `phase_o`=1, drop `enable_i` at `count`=2: STOPPING; half strobe at `count`=5; `phase_o`=0; `clock_active_o` falls and `clear_state_o` pulses once the next cycle.
- Same case with `phase_o`=0: IDLE the next cycle; no further strobes; `clear_state_o` pulse.
- `target_update_i` with 8 at `count`=1 while `T`=4: old period is completed, then period 8 with quarter strobe at `count`=3. Update coinciding with a boundary: new `T` applies immediately. `half_target_i`=0 → `T`=2.
- `clk_en` toggling 1/0, `T`=3: half strobes every 6 `clk` cycles; no strobe while `clk_en`=0. `enable_i` re-asserted in STOPPING: no `clear_state_o`, period unchanged.
- `async_rst_n` asserted mid-RUNNING: all outputs 0 immediately (asynchronous); after release the block is idle until `enable_i` is seen.
